// File: rtl/kpyd_entry_ctrl.sv
// Purpose : assembles debounced keypad events into multi-digit hex entries and hands them downstream.
// Latency : every key or handshake effect is visible on the registered outputs one cycle later.
// Backpres: entry_valid_o holds until entry_ready_i; keys arriving meanwhile are dropped (drop_o).
//
// Ports:
//   clk_i, reset_ni          clock, asynchronous active-low reset
//   key_valid_i/key_symbol_i one-cycle key event, 0x0-0xD digit, 0xE enter, 0xF clear/backspace
//   entry_o                  assembled entry, newest digit in [3:0]
//   entry_valid_o            entry_o holds a committed entry (valid/ready with entry_ready_i)
//   digit_count_o            digits currently held
//   busy_o                   not idle
//   drop_o, timeout_o        one-cycle event pulses
//
// Build option: define KPYD_ENTRY_BACKSPACE_EN to make 0xF delete the newest digit
// instead of clearing the whole entry.
module kpyd_entry_ctrl #(
   parameter int DIGITS         = 4,
   parameter int TIMEOUT_CYCLES = 50000000
) (
   input  logic                         clk_i,
   input  logic                         reset_ni,
   input  logic                         key_valid_i,
   input  logic [3:0]                   key_symbol_i,
   output logic [4*DIGITS-1:0]          entry_o,
   output logic                         entry_valid_o,
   input  logic                         entry_ready_i,
   output logic [$clog2(DIGITS+1)-1:0]  digit_count_o,
   output logic                         busy_o,
   output logic                         drop_o,
   output logic                         timeout_o
);

   localparam int EW = 4 * DIGITS;
   localparam int CW = $clog2(DIGITS + 1);
   localparam int TW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

   localparam logic [CW-1:0] MAX_CNT   = CW'(DIGITS);
   localparam logic [CW-1:0] ONE_CNT   = CW'(1);
   localparam logic [TW-1:0] TO_LAST   = (TIMEOUT_CYCLES > 0) ? TW'(TIMEOUT_CYCLES - 1) : '0;
   localparam logic [3:0]    SYM_ENTER = 4'hE;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      COLLECT = 2'd1,
      PRESENT = 2'd2
   } state_t;

   state_t          state, state_nxt;
   logic [EW-1:0]   entry, entry_nxt;
   logic [CW-1:0]   count, count_nxt;
   logic [TW-1:0]   idle_cnt, idle_cnt_nxt;
   logic            drop_nxt, timeout_nxt;
   logic [EW+3:0]   shifted_wide;
   logic            is_digit;
   logic            expire;

   // Appending the new digit below the old entry; the top nibble falls off when truncated.
   assign shifted_wide = {entry, key_symbol_i};
   assign is_digit     = (key_symbol_i < SYM_ENTER);

   // A key in the expiry cycle takes priority over the timeout.
   assign expire = (TIMEOUT_CYCLES > 0) && (state == COLLECT) && !key_valid_i &&
                   (idle_cnt == TO_LAST);

   always_comb begin
      state_nxt   = state;
      entry_nxt   = entry;
      count_nxt   = count;
      drop_nxt    = 1'b0;
      timeout_nxt = 1'b0;

      case (state)
         IDLE, COLLECT: begin
            if (key_valid_i) begin
               if (is_digit) begin
                  if (count < MAX_CNT) begin
                     entry_nxt = shifted_wide[EW-1:0];
                     count_nxt = count + 1'b1;
                     state_nxt = COLLECT;
                  end else begin
                     drop_nxt = 1'b1;
                  end
               end else if (key_symbol_i == SYM_ENTER) begin
                  // Enter with nothing typed is silently ignored.
                  if (state == COLLECT) begin
                     state_nxt = PRESENT;
                  end
               end else begin
`ifdef KPYD_ENTRY_BACKSPACE_EN
                  if (state == COLLECT) begin
                     entry_nxt = entry >> 4;
                     count_nxt = count - 1'b1;
                     if (count == ONE_CNT) begin
                        state_nxt = IDLE;
                     end
                  end
`else
                  entry_nxt = '0;
                  count_nxt = '0;
                  state_nxt = IDLE;
`endif
               end
            end else if (expire) begin
               entry_nxt   = '0;
               count_nxt   = '0;
               state_nxt   = IDLE;
               timeout_nxt = 1'b1;
            end
         end

         PRESENT: begin
            // The entry is frozen here; every key is discarded, even alongside a handshake.
            if (key_valid_i) begin
               drop_nxt = 1'b1;
            end
            if (entry_ready_i) begin
               entry_nxt = '0;
               count_nxt = '0;
               state_nxt = IDLE;
            end
         end

         default: begin
            entry_nxt = '0;
            count_nxt = '0;
            state_nxt = IDLE;
         end
      endcase
   end

   // Idle counter only runs on quiet cycles spent inside COLLECT.
   always_comb begin
      idle_cnt_nxt = idle_cnt + 1'b1;
      if ((TIMEOUT_CYCLES == 0) || (state != COLLECT) || (state_nxt != COLLECT) || key_valid_i) begin
         idle_cnt_nxt = '0;
      end
   end

   always_ff @(posedge clk_i or negedge reset_ni) begin
      if (!reset_ni) begin
         state         <= IDLE;
         entry         <= '0;
         count         <= '0;
         idle_cnt      <= '0;
         entry_valid_o <= 1'b0;
         busy_o        <= 1'b0;
         drop_o        <= 1'b0;
         timeout_o     <= 1'b0;
      end else begin
         state         <= state_nxt;
         entry         <= entry_nxt;
         count         <= count_nxt;
         idle_cnt      <= idle_cnt_nxt;
         entry_valid_o <= (state_nxt == PRESENT);
         busy_o        <= (state_nxt != IDLE);
         drop_o        <= drop_nxt;
         timeout_o     <= timeout_nxt;
      end
   end

   assign entry_o       = entry;
   assign digit_count_o = count;

endmodule

// File: tb/tb_kpyd_entry_ctrl.sv
// Bench for kpyd_entry_ctrl (DIGITS=4, TIMEOUT_CYCLES=8).
// Table-driven vectors feed a scoreboard queue; outputs are compared #1 after each rising edge.
// Hand-written sequences cover reset state and an asynchronous reset mid-entry.
module tb_kpyd_entry_ctrl;

   logic        clk;
   logic        rst_n;
   logic        key_valid;
   logic [3:0]  key_symbol;
   logic [15:0] entry;
   logic        entry_valid;
   logic        entry_ready;
   logic [2:0]  digit_count;
   logic        busy;
   logic        drop;
   logic        timeout;

   int checks   = 0;
   int failures = 0;

   typedef struct packed {
      logic [15:0] entry;
      logic        vld;
      logic [2:0]  cnt;
      logic        busy;
      logic        drop;
      logic        tmo;
   } exp_t;

   typedef struct {
      string      name;
      logic       kv;
      logic [3:0] sym;
      logic       rdy;
      exp_t       exp;
   } vec_t;

   vec_t  vecs[$];
   exp_t  sb[$];
   string sb_name[$];

   kpyd_entry_ctrl #(.DIGITS(4), .TIMEOUT_CYCLES(8)) dut (
      .clk_i         (clk),
      .reset_ni      (rst_n),
      .key_valid_i   (key_valid),
      .key_symbol_i  (key_symbol),
      .entry_o       (entry),
      .entry_valid_o (entry_valid),
      .entry_ready_i (entry_ready),
      .digit_count_o (digit_count),
      .busy_o        (busy),
      .drop_o        (drop),
      .timeout_o     (timeout)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not complete within time limit");
      $fatal(1, "watchdog");
   end

   function automatic vec_t mk(string n, logic kv, logic [3:0] s, logic r,
                               logic [15:0] e, logic v, logic [2:0] c,
                               logic b, logic d, logic t);
      vec_t x;
      x.name     = n;
      x.kv       = kv;
      x.sym      = s;
      x.rdy      = r;
      x.exp.entry = e;
      x.exp.vld  = v;
      x.exp.cnt  = c;
      x.exp.busy = b;
      x.exp.drop = d;
      x.exp.tmo  = t;
      return x;
   endfunction

   function automatic exp_t sample();
      exp_t g;
      g.entry = entry;
      g.vld   = entry_valid;
      g.cnt   = digit_count;
      g.busy  = busy;
      g.drop  = drop;
      g.tmo   = timeout;
      return g;
   endfunction

   task automatic compare(input string name, input exp_t got, input exp_t exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got entry=%h vld=%b cnt=%0d busy=%b drop=%b tmo=%b, expected entry=%h vld=%b cnt=%0d busy=%b drop=%b tmo=%b",
                  name, got.entry, got.vld, got.cnt, got.busy, got.drop, got.tmo,
                  exp.entry, exp.vld, exp.cnt, exp.busy, exp.drop, exp.tmo);
      end
   endtask

   // Drive one cycle of stimulus, queue its expectation, then check after the edge.
   task automatic drive_check(input vec_t v);
      exp_t e;
      string n;
      @(negedge clk);
      key_valid   = v.kv;
      key_symbol  = v.sym;
      entry_ready = v.rdy;
      sb.push_back(v.exp);
      sb_name.push_back(v.name);
      @(posedge clk);
      #1;
      e = sb.pop_front();
      n = sb_name.pop_front();
      compare(n, sample(), e);
      key_valid   = 1'b0;
      key_symbol  = 4'h0;
      entry_ready = 1'b0;
   endtask

   initial begin
      exp_t zero;
      exp_t bs_exp;
      zero = '0;

      // ---------------- vector table ----------------
      // name, kv, sym, rdy, entry, vld, cnt, busy, drop, tmo
      vecs.push_back(mk("t1_idle",          0, 4'h0, 0, 16'h0000, 0, 0, 0, 0, 0));
      vecs.push_back(mk("t1_k1_rdy_ignored",1, 4'h1, 1, 16'h0001, 0, 1, 1, 0, 0));
      vecs.push_back(mk("t1_k2",            1, 4'h2, 0, 16'h0012, 0, 2, 1, 0, 0));
      vecs.push_back(mk("t1_k3",            1, 4'h3, 0, 16'h0123, 0, 3, 1, 0, 0));
      vecs.push_back(mk("t1_enter",         1, 4'hE, 0, 16'h0123, 1, 3, 1, 0, 0));
      vecs.push_back(mk("t1_hold",          0, 4'h0, 0, 16'h0123, 1, 3, 1, 0, 0));
      vecs.push_back(mk("t1_handshake",     0, 4'h0, 1, 16'h0000, 0, 0, 0, 0, 0));
      vecs.push_back(mk("t1_after",         0, 4'h0, 0, 16'h0000, 0, 0, 0, 0, 0));

      vecs.push_back(mk("t2_k1",            1, 4'h1, 0, 16'h0001, 0, 1, 1, 0, 0));
      vecs.push_back(mk("t2_k2",            1, 4'h2, 0, 16'h0012, 0, 2, 1, 0, 0));
      vecs.push_back(mk("t2_k3",            1, 4'h3, 0, 16'h0123, 0, 3, 1, 0, 0));
      vecs.push_back(mk("t2_k4",            1, 4'h4, 0, 16'h1234, 0, 4, 1, 0, 0));
      vecs.push_back(mk("t2_k5_full_drop",  1, 4'h5, 0, 16'h1234, 0, 4, 1, 1, 0));
      vecs.push_back(mk("t2_enter",         1, 4'hE, 0, 16'h1234, 1, 4, 1, 0, 0));
      vecs.push_back(mk("t2_handshake",     0, 4'h0, 1, 16'h0000, 0, 0, 0, 0, 0));

      vecs.push_back(mk("t3_kA",            1, 4'hA, 0, 16'h000A, 0, 1, 1, 0, 0));
      vecs.push_back(mk("t3_kB",            1, 4'hB, 0, 16'h00AB, 0, 2, 1, 0, 0));
      vecs.push_back(mk("t3_enter",         1, 4'hE, 0, 16'h00AB, 1, 2, 1, 0, 0));
      for (int i = 0; i < 10; i++)
         vecs.push_back(mk($sformatf("t3_stall%0d", i), 0, 4'h0, 0, 16'h00AB, 1, 2, 1, 0, 0));
      vecs.push_back(mk("t3_k7_present_drop",1, 4'h7, 0, 16'h00AB, 1, 2, 1, 1, 0));
      vecs.push_back(mk("t3_drop_ends",     0, 4'h0, 0, 16'h00AB, 1, 2, 1, 0, 0));
      vecs.push_back(mk("t3_F_present_drop",1, 4'hF, 0, 16'h00AB, 1, 2, 1, 1, 0));
      vecs.push_back(mk("t3_handshake",     0, 4'h0, 1, 16'h0000, 0, 0, 0, 0, 0));

      vecs.push_back(mk("hk_k1",            1, 4'h1, 0, 16'h0001, 0, 1, 1, 0, 0));
      vecs.push_back(mk("hk_enter",         1, 4'hE, 0, 16'h0001, 1, 1, 1, 0, 0));
      vecs.push_back(mk("hk_key_and_hs",    1, 4'h5, 1, 16'h0000, 0, 0, 0, 1, 0));
      vecs.push_back(mk("hk_after",         0, 4'h0, 0, 16'h0000, 0, 0, 0, 0, 0));

      vecs.push_back(mk("t6_E_in_idle",     1, 4'hE, 0, 16'h0000, 0, 0, 0, 0, 0));
      vecs.push_back(mk("t6_F_in_idle",     1, 4'hF, 0, 16'h0000, 0, 0, 0, 0, 0));

      vecs.push_back(mk("t4_k5",            1, 4'h5, 0, 16'h0005, 0, 1, 1, 0, 0));
      for (int i = 1; i <= 7; i++)
         vecs.push_back(mk($sformatf("t4_wait%0d", i), 0, 4'h0, 0, 16'h0005, 0, 1, 1, 0, 0));
      vecs.push_back(mk("t4_timeout",       0, 4'h0, 0, 16'h0000, 0, 0, 0, 0, 1));
      vecs.push_back(mk("t4_timeout_ends",  0, 4'h0, 0, 16'h0000, 0, 0, 0, 0, 0));
      vecs.push_back(mk("t4b_k5",           1, 4'h5, 0, 16'h0005, 0, 1, 1, 0, 0));
      for (int i = 1; i <= 6; i++)
         vecs.push_back(mk($sformatf("t4b_wait%0d", i), 0, 4'h0, 0, 16'h0005, 0, 1, 1, 0, 0));
      vecs.push_back(mk("t4b_k6_restart",   1, 4'h6, 0, 16'h0056, 0, 2, 1, 0, 0));
      for (int i = 1; i <= 7; i++)
         vecs.push_back(mk($sformatf("t4b_wait2_%0d", i), 0, 4'h0, 0, 16'h0056, 0, 2, 1, 0, 0));
      vecs.push_back(mk("t4b_enter_beats_timeout", 1, 4'hE, 0, 16'h0056, 1, 2, 1, 0, 0));
      vecs.push_back(mk("t4b_handshake",    0, 4'h0, 1, 16'h0000, 0, 0, 0, 0, 0));

      vecs.push_back(mk("t5_k9",            1, 4'h9, 0, 16'h0009, 0, 1, 1, 0, 0));
      vecs.push_back(mk("t5_k8",            1, 4'h8, 0, 16'h0098, 0, 2, 1, 0, 0));
`ifdef KPYD_ENTRY_BACKSPACE_EN
      vecs.push_back(mk("t5_F",             1, 4'hF, 0, 16'h0009, 0, 1, 1, 0, 0));
`else
      vecs.push_back(mk("t5_F",             1, 4'hF, 0, 16'h0000, 0, 0, 0, 0, 0));
`endif
      vecs.push_back(mk("t5_F_again",       1, 4'hF, 0, 16'h0000, 0, 0, 0, 0, 0));
      vecs.push_back(mk("t5_F_idle",        1, 4'hF, 0, 16'h0000, 0, 0, 0, 0, 0));

      // ---------------- reset state ----------------
      rst_n       = 1'b1;
      key_valid   = 1'b0;
      key_symbol  = 4'h0;
      entry_ready = 1'b0;
      #2;
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      compare("reset_state", sample(), zero);
      @(negedge clk);
      rst_n = 1'b1;

      // ---------------- table ----------------
      foreach (vecs[i]) drive_check(vecs[i]);

      // ---------------- asynchronous reset mid-COLLECT ----------------
      drive_check(mk("t6_k3", 1, 4'h3, 0, 16'h0003, 0, 1, 1, 0, 0));
      drive_check(mk("t6_k4", 1, 4'h4, 0, 16'h0034, 0, 2, 1, 0, 0));
      #2;
      rst_n = 1'b0;
      #1;
      compare("t6_async_reset", sample(), zero);
      @(negedge clk);
      rst_n = 1'b1;
      drive_check(mk("t6_after_reset", 0, 4'h0, 0, 16'h0000, 0, 0, 0, 0, 0));
      bs_exp = '0;
      bs_exp.entry = 16'h0007;
      bs_exp.cnt   = 3'd1;
      bs_exp.busy  = 1'b1;
      drive_check(mk("t6_k7_fresh", 1, 4'h7, 0, bs_exp.entry, bs_exp.vld, bs_exp.cnt,
                     bs_exp.busy, bs_exp.drop, bs_exp.tmo));

      if (sb.size() != 0) begin
         failures++;
         $display("FAIL scoreboard_drain: got %0d leftover entries, expected 0", sb.size());
      end
      checks++;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
